adder_share_arbiter: RTL and testbench

//  Shares one combinational 16-bit Kogge-Stone prefix adder (sum[15:0], cout, carry-in fixed 0)

---
 rtl/adder_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_adder_share_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin shares one 16-bit Kogge-Stone adder among NREQ valid/ready clients.
// The path is two stages: an operand register, then the adder into a result register.

module ks_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);
  logic [4:0][15:0] g;
  logic [3:0][15:0] p;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar s = 0; s < 4; s++) begin : g_lvl
    localparam int D = 1 << s;
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign g[s+1][i] = g[s][i] | (p[s][i] & g[s][i-D]);
        if (s < 3) begin : g_p
          assign p[s+1][i] = p[s][i] & p[s][i-D];
        end
      end else begin : g_pass
        assign g[s+1][i] = g[s][i];
        if (s < 3) begin : g_p
          assign p[s+1][i] = p[s][i];
        end
      end
    end
  end

  // g[4][i] is the carry out of bit i; carry-in is fixed at 0.
  assign sum  = p[0] ^ {g[4][14:0], 1'b0};
  assign cout = g[4][15];
endmodule

module adder_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ),
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    busy
);
  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  s1_t              s1;
  logic             v1, v2;
  logic [IDW-1:0]   ptr, gid;
  logic [NREQ-1:0]  grant;
  logic             found, adv1, adv2, hs;
  logic [WIDTH-1:0] sel_a, sel_b, add_sum;
  logic             add_cout;

  assign adv2 = v1 & (~v2 | rsp_ready);
  assign adv1 = ~v1 | adv2;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && ((int'(ptr) + k) % NREQ == i)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gid      = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[WIDTH*i +: WIDTH];
        sel_b = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Reset gating keeps req_ready low while rst is held, even with an empty pipe.
  assign hs        = found & adv1 & ~rst;
  assign req_ready = grant & {NREQ{adv1 & ~rst}};
  assign rsp_valid = v2;
  assign busy      = v1 | v2;

  ks_add16 u_add (
    .a    (s1.a),
    .b    (s1.b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      s1  <= '0;
      ptr <= '0;
    end else if (adv1) begin
      v1 <= hs;
      if (hs) begin
        s1  <= '{id: gid, a: sel_a, b: sel_b};
        ptr <= IDW'((int'(gid) + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else if (adv2) begin
      v2       <= 1'b1;
      rsp_id   <= s1.id;
      rsp_sum  <= add_sum;
      rsp_cout <= add_cout;
    end else if (rsp_ready) begin
      v2 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed and random checks of adder_share_arbiter against a queue-based model
// that treats the pipeline as a depth-2 FIFO with a one-cycle minimum residency.

module tb_adder_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*16-1:0]   req_a = '0;
  logic [NREQ*16-1:0]   req_b = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          rsp_sum;
  logic                 rsp_cout;
  logic                 busy;

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ptr = 0;
  int q_id[$];
  int q_res[$];
  int q_age[$];
  int wt[NREQ];
  int max_wt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic model_reset();
    ptr = 0;
    q_id.delete();
    q_res.delete();
    q_age.delete();
    for (int i = 0; i < NREQ; i++) wt[i] = 0;
  endtask

  // One cycle: check at negedge, advance the model at posedge, return at posedge+1.
  task automatic step();
    int cnt, g, idx, res;
    logic ev, acc;
    logic [NREQ-1:0] er;
    @(negedge clk);
    cnt = q_id.size();
    ev  = (cnt == 2) || (cnt == 1 && q_age[0] >= 1);
    acc = (cnt <= 1) || rsp_ready;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    er = '0;
    if (acc && g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(cnt > 0));
    if (ev) begin
      chk("rsp_id", 32'(rsp_id), q_id[0]);
      chk("rsp_cout_sum", {15'b0, rsp_cout, rsp_sum}, q_res[0]);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i] || (er != 0 && i == g)) wt[i] = 0;
      else if (er != 0) begin
        wt[i]++;
        if (wt[i] > max_wt) max_wt = wt[i];
      end
    end
    res = 0;
    if (g >= 0) res = int'(req_a[16*g +: 16]) + int'(req_b[16*g +: 16]);
    @(posedge clk);
    if (ev && rsp_ready) begin
      void'(q_id.pop_front());
      void'(q_res.pop_front());
      void'(q_age.pop_front());
    end
    foreach (q_age[j]) q_age[j]++;
    if (er != 0) begin
      q_id.push_back(g);
      q_res.push_back(res);
      q_age.push_back(0);
      ptr = (g + 1) % NREQ;
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_sum", 32'(rsp_sum), 0);
    chk("rst_rsp_cout", 32'(rsp_cout), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single op: result two cycles after the handshake.
    rsp_ready = 1'b1;
    set_op(0, 16'h1234, 16'h0FFF);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_sum", 32'(rsp_sum), 32'h2233);
    chk("t1_cout", 32'(rsp_cout), 0);
    chk("t1_id", 32'(rsp_id), 0);
    step();

    // Carry out of bit 15.
    set_op(1, 16'hFFFF, 16'h0001);
    req_valid = 4'b0010;
    step();
    set_op(1, 16'h8000, 16'h8000);
    step();
    req_valid = '0;
    chk("t2a_sum", 32'(rsp_sum), 0);
    chk("t2a_cout", 32'(rsp_cout), 1);
    step();
    chk("t2b_valid", 32'(rsp_valid), 1);
    chk("t2b_sum", 32'(rsp_sum), 0);
    chk("t2b_cout", 32'(rsp_cout), 1);
    step();
    step();

    // Round robin from reset, all requesters continuously valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(16'h1000 * (i + 1)), 16'(i));
    req_valid = '1;
    for (int n = 0; n < 12; n++) step();

    // Backpressure mid-stream, then release and drain.
    rsp_ready = 1'b0;
    for (int n = 0; n < 5; n++) step();
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) step();
    req_valid = '0;
    for (int n = 0; n < 4; n++) step();
    chk("bp_drained", 32'(q_id.size()), 0);

    // Asynchronous reset with both stages occupied.
    req_valid = '1;
    for (int n = 0; n < 3; n++) step();
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 0);
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_rsp_id", 32'(rsp_id), 0);
    chk("arst_rsp_sum", 32'(rsp_sum), 0);
    chk("arst_rsp_cout", 32'(rsp_cout), 0);
    chk("arst_busy", 32'(busy), 0);
    model_reset();
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    set_op(2, 16'hABCD, 16'h1111);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    for (int n = 0; n < 3; n++) step();

    // Random traffic against the model.
    max_wt = 0;
    for (int n = 0; n < 10000; n++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) step();
    chk("rand_drained", 32'(q_id.size()), 0);
    chk("max_wait_ok", 32'(max_wt <= NREQ - 1), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
